// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit sides.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 104;

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StStart,
    StData,
    StStop
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Received-byte handshake and status bundle between the UART receiver and its consumer.
interface uart_rx_sampler_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      frame_err;
  logic                      overrun;
  logic                      busy;

  modport master (
    output rx_data, rx_valid, frame_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun, busy,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module uart_rx_sync #(
  parameter int unsigned Width    = 1,
  parameter logic        ResetVal = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= {Width{ResetVal}};
      s2_q <= {Width{ResetVal}};
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready output register, framing and overrun pulses.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  uart_rx_sampler_if.master    rx_bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(UART_DATA_BITS);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_rx_sampler: CLKS_PER_BIT must be >= 4");
  end

  logic rxs;

  uart_rx_sync #(
    .Width    (1),
    .ResetVal (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (uart_rx),
    .q     (rxs)
  );

  uart_rx_state_e            state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ferr_q, ferr_d;
  logic                      ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && rx_bus.rx_ready) valid_d = 1'b0;

    unique case (state_q)
      StWaitIdle: begin
        if (rxs) state_d = StIdle;
      end
      StIdle: begin
        if (!rxs) begin
          cnt_d   = HalfLast;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs) begin
          state_d = StIdle;
        end else begin
          cnt_d   = BitLast;
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
          cnt_d   = BitLast;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxLast) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs) begin
          // Back to IDLE right at the stop sample so a following start edge is not missed.
          state_d = StIdle;
          if (!valid_q || rx_bus.rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          ferr_d  = 1'b1;
          state_d = StWaitIdle;
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWaitIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_bus.rx_data   = data_q;
  assign rx_bus.rx_valid  = valid_q;
  assign rx_bus.frame_err = ferr_q;
  assign rx_bus.overrun   = ovr_q;
  assign rx_bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at CLKS_PER_BIT=16 (N=16, H=8).
module tb_uart_rx_sampler;

  localparam int unsigned N = 16;

  logic clk = 1'b0;
  logic reset;
  logic uart_rx;

  uart_rx_sampler_if bus ();

  uart_rx_sampler #(
    .CLKS_PER_BIT (N)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .rx_bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int total;
  int bad;

  int unsigned valid_rise, valid_hi, ferr_hi, ovr_hi, both_hi;
  int unsigned rise_cyc, ferr_cyc, ovr_cyc;
  logic [7:0]  rise_data;
  logic        valid_prev = 1'b0;

  // Event monitor, sampled mid-cycle; cyc is the index of the current cycle.
  always @(negedge clk) begin
    if (bus.rx_valid) valid_hi++;
    if (bus.rx_valid && !valid_prev) begin
      valid_rise++;
      rise_cyc  = cyc;
      rise_data = bus.rx_data;
    end
    valid_prev = bus.rx_valid;
    if (bus.frame_err) begin
      ferr_hi++;
      ferr_cyc = cyc;
    end
    if (bus.overrun) begin
      ovr_hi++;
      ovr_cyc = cyc;
    end
    if (bus.frame_err && bus.overrun) both_hi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) tick(1);
  endtask

  // t0 = first cycle the receiver sees the synchronised start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int unsigned t0);
    t0 = cyc + 2;
    uart_rx = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(N);
    end
    uart_rx = stop;
    tick(N);
    uart_rx = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: sim time expired, got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int unsigned t0, t0b, s;
    int unsigned vr0, vh0, fh0, oh0;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    uart_rx = 1'b1;
    bus.rx_ready = 1'b0;

    // Reset state
    tick(3);
    check_eq("rst_data",  32'(bus.rx_data),   32'h00);
    check_eq("rst_valid", 32'(bus.rx_valid),  32'd0);
    check_eq("rst_ferr",  32'(bus.frame_err), 32'd0);
    check_eq("rst_ovr",   32'(bus.overrun),   32'd0);
    check_eq("rst_busy",  32'(bus.busy),      32'd1);
    reset = 1'b0;
    tick(4);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);

    // 1: frame 0x55 with consumer ready
    bus.rx_ready = 1'b1;
    vr0 = valid_rise; vh0 = valid_hi; fh0 = ferr_hi; oh0 = ovr_hi;
    send_frame(8'h55, 1'b1, t0);
    tick(20);
    check_eq("t1_rise_n",   valid_rise - vr0, 32'd1);
    check_eq("t1_rise_cyc", rise_cyc,         t0 + 153);
    check_eq("t1_valid_hi", valid_hi - vh0,   32'd1);
    check_eq("t1_data",     32'(rise_data),   32'h55);
    check_eq("t1_errs",     (ferr_hi - fh0) + (ovr_hi - oh0), 32'd0);

    // 2: 4-clock glitch is a false start
    vr0 = valid_rise; fh0 = ferr_hi;
    s = cyc;
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    wait_cyc(s + 2 + 5);
    check_eq("t2_busy_mid", 32'(bus.busy), 32'd1);
    wait_cyc(s + 2 + 9);
    check_eq("t2_busy_end", 32'(bus.busy), 32'd0);
    tick(200);
    check_eq("t2_no_evt", (valid_rise - vr0) + (ferr_hi - fh0), 32'd0);

    // 3: 0xA3 with low stop bit, line stays low 40 clocks, then 0x41
    vr0 = valid_rise; fh0 = ferr_hi;
    send_frame(8'hA3, 1'b0, t0);
    uart_rx = 1'b0;
    tick(40 - N);
    check_eq("t3_ferr_hi",  ferr_hi - fh0,    32'd1);
    check_eq("t3_ferr_cyc", ferr_cyc,         t0 + 153);
    check_eq("t3_no_valid", valid_rise - vr0, 32'd0);
    check_eq("t3_busy_low", 32'(bus.busy),    32'd1);
    uart_rx = 1'b1;
    tick(4);
    check_eq("t3_busy_rel", 32'(bus.busy),    32'd0);
    vr0 = valid_rise;
    send_frame(8'h41, 1'b1, t0);
    tick(20);
    check_eq("t3_next_n",    valid_rise - vr0, 32'd1);
    check_eq("t3_next_data", 32'(rise_data),   32'h41);

    // 4: back-to-back 0x31, 0x32 with consumer stalled
    bus.rx_ready = 1'b0;
    vr0 = valid_rise; oh0 = ovr_hi;
    send_frame(8'h31, 1'b1, t0);
    send_frame(8'h32, 1'b1, t0b);
    tick(20);
    check_eq("t4_rise_n",  valid_rise - vr0,  32'd1);
    check_eq("t4_data",    32'(bus.rx_data),  32'h31);
    check_eq("t4_valid",   32'(bus.rx_valid), 32'd1);
    check_eq("t4_ovr_hi",  ovr_hi - oh0,      32'd1);
    check_eq("t4_ovr_cyc", ovr_cyc,           t0b + 153);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    check_eq("t4_drained", 32'(bus.rx_valid), 32'd0);

    // 5: handshake in the stop-sample cycle coincides with the new load
    send_frame(8'h10, 1'b1, t0);
    tick(20);
    check_eq("t5_old_data", 32'(bus.rx_data), 32'h10);
    oh0 = ovr_hi;
    s = cyc;
    fork
      send_frame(8'h20, 1'b1, t0b);
      begin
        wait_cyc(s + 2 + 152);
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        check_eq("t5_new_data", 32'(bus.rx_data),  32'h20);
        check_eq("t5_valid",    32'(bus.rx_valid), 32'd1);
      end
    join
    tick(5);
    check_eq("t5_valid_kept", 32'(bus.rx_valid), 32'd1);
    check_eq("t5_no_ovr",     ovr_hi - oh0,      32'd0);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;

    // 6: reset during data bit 3 while the line is low
    vr0 = valid_rise; fh0 = ferr_hi;
    uart_rx = 1'b0;
    tick(N);
    uart_rx = 1'b1;
    tick(3 * N);
    uart_rx = 1'b0;
    tick(N / 2);
    reset = 1'b1;
    tick(1);
    check_eq("t6_data",  32'(bus.rx_data),   32'h00);
    check_eq("t6_valid", 32'(bus.rx_valid),  32'd0);
    check_eq("t6_ferr",  32'(bus.frame_err), 32'd0);
    check_eq("t6_ovr",   32'(bus.overrun),   32'd0);
    check_eq("t6_busy",  32'(bus.busy),      32'd1);
    tick(2);
    reset = 1'b0;
    uart_rx = 1'b1;
    tick(12 * N);
    check_eq("t6_no_evt", (valid_rise - vr0) + (ferr_hi - fh0), 32'd0);
    bus.rx_ready = 1'b1;
    vr0 = valid_rise;
    send_frame(8'h7E, 1'b1, t0);
    tick(20);
    check_eq("t6_next_n",    valid_rise - vr0, 32'd1);
    check_eq("t6_next_data", 32'(rise_data),   32'h7E);
    check_eq("t6_next_cyc",  rise_cyc,         t0 + 153);

    check_eq("err_exclusive", both_hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
